// File: rtl/cordic_arbiter.sv
// rtl/cordic_arbiter.sv - round-robin arbiter sharing one CORDIC among N requesters
// Optional WAIT-state abort after TIMEOUT cycles when CORDIC_ARB_TIMEOUT_EN is defined.
module cordic_arbiter #(
    parameter int N       = 4,
    parameter int WL      = 10,
    parameter int TIMEOUT = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N-1:0]         req,
    input  logic [N*WL-1:0]      req_angle,
    output logic [N-1:0]         ack,
    output logic                 rsp_valid,
    output logic [$clog2(N)-1:0] rsp_id,
    output logic [WL-1:0]        rsp_cos,
    output logic [WL-1:0]        rsp_sin,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 cordic_start,
    output logic [WL-1:0]        cordic_angle,
    input  logic [WL-1:0]        cordic_cos,
    input  logic [WL-1:0]        cordic_sin,
    input  logic                 cordic_done
);
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t          r_state;
    logic [IW-1:0]   r_last;
    logic [N-1:0]    r_ack;
    logic            r_rsp_valid;
    logic [IW-1:0]   r_rsp_id;
    logic [WL-1:0]   r_rsp_cos;
    logic [WL-1:0]   r_rsp_sin;
    logic            r_busy;
    logic            r_start;
    logic [WL-1:0]   r_angle;

    logic [WL-1:0]   w_angles [N];
    logic            w_gnt_vld;
    logic [IW-1:0]   w_gnt_idx;
    int              w_idx;

    for (genvar g = 0; g < N; g++) begin : g_angle
        assign w_angles[g] = req_angle[g*WL +: WL];
    end

    // Scan from farthest to nearest offset so the requester right after r_last wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_idx     = 0;
        for (int i = N; i >= 1; i--) begin
            w_idx = int'(r_last) + i;
            if (w_idx >= N) w_idx = w_idx - N;
            if (req[w_idx[IW-1:0]]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_idx[IW-1:0];
            end
        end
    end

`ifdef CORDIC_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]   r_wait_cnt;
    logic            r_rsp_err;
    assign rsp_err = r_rsp_err;
`else
    logic            w_unused;
    assign w_unused = (TIMEOUT > 0);
    assign rsp_err  = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_last      <= IW'(N - 1);
            r_ack       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_cos   <= '0;
            r_rsp_sin   <= '0;
            r_busy      <= 1'b0;
            r_start     <= 1'b0;
            r_angle     <= '0;
`ifdef CORDIC_ARB_TIMEOUT_EN
            r_wait_cnt  <= '0;
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            r_ack       <= '0;
            r_start     <= 1'b0;
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_vld) begin
                        r_ack    <= {{(N-1){1'b0}}, 1'b1} << w_gnt_idx;
                        r_angle  <= w_angles[w_gnt_idx];
                        r_rsp_id <= w_gnt_idx;
                        r_last   <= w_gnt_idx;
                        r_busy   <= 1'b1;
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_start <= 1'b1;
                    r_state <= S_WAIT;
`ifdef CORDIC_ARB_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                end
                S_WAIT: begin
                    if (cordic_done) begin
                        r_rsp_cos   <= cordic_cos;
                        r_rsp_sin   <= cordic_sin;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
`ifdef CORDIC_ARB_TIMEOUT_EN
                        r_rsp_err   <= 1'b0;
                    end else if (r_wait_cnt == CW'(TIMEOUT - 1)) begin
                        r_rsp_cos   <= '0;
                        r_rsp_sin   <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_wait_cnt  <= r_wait_cnt + 1'b1;
`endif
                    end
                end
                S_RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ack          = r_ack;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_id       = r_rsp_id;
    assign rsp_cos      = r_rsp_cos;
    assign rsp_sin      = r_rsp_sin;
    assign busy         = r_busy;
    assign cordic_start = r_start;
    assign cordic_angle = r_angle;
endmodule

// File: tb/tb_cordic_arbiter.sv
// tb/tb_cordic_arbiter.sv - self-checking bench for cordic_arbiter
module tb_cordic_arbiter;
    localparam int N = 4;
    localparam int WL = 10;
    localparam int TIMEOUT = 32;

    logic            CLK = 1'b0;
    logic            RST;
    logic [N-1:0]    req;
    logic [N*WL-1:0] req_angle;
    logic [N-1:0]    ack;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic [WL-1:0]   rsp_cos, rsp_sin;
    logic            rsp_err, busy, cordic_start;
    logic [WL-1:0]   cordic_angle;
    logic [WL-1:0]   cordic_cos, cordic_sin;
    logic            cordic_done;

    logic [WL-1:0]   ang [N];
    assign req_angle = {ang[3], ang[2], ang[1], ang[0]};

    cordic_arbiter #(.N(N), .WL(WL), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST), .req(req), .req_angle(req_angle), .ack(ack),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_cos(rsp_cos), .rsp_sin(rsp_sin),
        .rsp_err(rsp_err), .busy(busy), .cordic_start(cordic_start),
        .cordic_angle(cordic_angle), .cordic_cos(cordic_cos), .cordic_sin(cordic_sin),
        .cordic_done(cordic_done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int            id;
        logic [WL-1:0] c;
        logic [WL-1:0] s;
        logic          err;
    } rsp_t;

    typedef struct {
        logic [N-1:0] mask;
        logic [15:0]  ord;
        int           n;
    } vec_t;

    rsp_t          q[$];
    rsp_t          mon_e;
    int            n_chk = 0, n_fail = 0, cyc = 0;
    int            t_ack, t_start, t_rsp, n_ack = 0, n_rsp = 0;
    logic [WL-1:0] start_angle;
    logic [N-1:0]  prev_ack = '0;
    int            stub_mode, stub_cnt;
    logic [WL-1:0] stub_ang;

    function automatic logic [WL-1:0] m_cos(input logic [WL-1:0] a);
        return a * 10'd3 + 10'd7;
    endfunction

    function automatic logic [WL-1:0] m_sin(input logic [WL-1:0] a);
        return a ^ 10'h2AA;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // CORDIC model: mode 0 = done 2 cycles after start, 1 = never done, 2 = done held high
    initial begin
        cordic_done = 1'b0; cordic_cos = '0; cordic_sin = '0; stub_cnt = 0; stub_ang = '0;
        forever begin
            @(posedge CLK); #1;
            cordic_done = 1'b0;
            if (RST) stub_cnt = 0;
            else if (cordic_start) begin
                stub_ang = cordic_angle;
                stub_cnt = 2;
            end else if (stub_cnt > 0) begin
                stub_cnt--;
                if (stub_cnt == 0 && stub_mode == 0) begin
                    cordic_done = 1'b1;
                    cordic_cos  = m_cos(stub_ang);
                    cordic_sin  = m_sin(stub_ang);
                end
            end
            if (stub_mode == 2) begin
                cordic_done = 1'b1;
                cordic_cos  = m_cos(stub_ang);
                cordic_sin  = m_sin(stub_ang);
            end
        end
    end

    always @(negedge CLK) begin
        if (!RST) begin
            if (ack != '0) begin
                n_ack++;
                t_ack = cyc;
                chk("ack_onehot", longint'($onehot(ack)), 1);
                chk("ack_one_cycle", prev_ack, 0);
            end
            if (cordic_start) begin
                t_start     = cyc;
                start_angle = cordic_angle;
            end
            if (rsp_valid) begin
                n_rsp++;
                t_rsp = cyc;
                chk("rsp_expected", longint'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    mon_e = q.pop_front();
                    chk("rsp_id", rsp_id, mon_e.id);
                    chk("rsp_cos", rsp_cos, mon_e.c);
                    chk("rsp_sin", rsp_sin, mon_e.s);
                    chk("rsp_err", rsp_err, mon_e.err);
                end
            end
        end
        prev_ack = ack;
    end

    task automatic do_reset();
        RST = 1'b1;
        req = '0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        q.delete();
    endtask

    task automatic run_batch(input logic [N-1:0] mask, input logic [15:0] ord, input int n,
                             input string tag);
        int   got;
        int   k;
        rsp_t e;
        got = 0;
        req = req | mask;
        for (int c = 0; c < 400 && (got < n || q.size() != 0 || busy); c++) begin
            @(negedge CLK); #1;
            if (ack != '0) begin
                if (got < n) begin
                    k = int'(ord[4*got +: 4]);
                    chk({tag, "_grant"}, ack, longint'(1) << k);
                    e.id = k; e.c = m_cos(ang[k]); e.s = m_sin(ang[k]); e.err = 1'b0;
                    q.push_back(e);
                end else begin
                    chk({tag, "_extra_ack"}, ack, 0);
                end
                req = req & ~ack;
                got++;
            end
        end
        chk({tag, "_complete"}, longint'(got == n && q.size() == 0 && !busy), 1);
    endtask

    task automatic wait_ack(input string tag, input logic [N-1:0] exp_mask);
        int seen;
        seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            @(negedge CLK); #1;
            if (ack != '0) begin
                chk(tag, ack, exp_mask);
                req  = req & ~ack;
                seen = 1;
            end
        end
        chk({tag, "_seen"}, seen, 1);
    endtask

    initial begin
        vec_t vt[7];
        int   a0, r0;
        rsp_t e;
        vt[0] = '{mask: 4'b1111, ord: 16'h3210, n: 4};
        vt[1] = '{mask: 4'b0001, ord: 16'h0000, n: 1};
        vt[2] = '{mask: 4'b1010, ord: 16'h0031, n: 2};
        vt[3] = '{mask: 4'b0101, ord: 16'h0020, n: 2};
        vt[4] = '{mask: 4'b1100, ord: 16'h0023, n: 2};
        vt[5] = '{mask: 4'b0110, ord: 16'h0021, n: 2};
        vt[6] = '{mask: 4'b1001, ord: 16'h0003, n: 2};

        stub_mode = 0;
        req = '0;
        for (int k = 0; k < N; k++) ang[k] = '0;
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        chk("rst_ack", ack, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", cordic_start, 0);
        chk("rst_angle", cordic_angle, 0);
        chk("rst_cos", rsp_cos, 0);
        chk("rst_id", rsp_id, 0);
        RST = 1'b0;

        ang[0] = 10'd28;
        run_batch(4'b0001, 16'h0000, 1, "single");
        chk("single_start_lat", t_start - t_ack, 1);
        chk("single_start_angle", start_angle, 28);
        chk("single_rsp_lat", t_rsp - t_ack, 4);
        repeat (3) @(negedge CLK);
        chk("hold_cos", rsp_cos, m_cos(10'd28));
        chk("hold_sin", rsp_sin, m_sin(10'd28));

        do_reset();
        for (int r = 0; r < 7; r++) begin
            for (int k = 0; k < N; k++) ang[k] = 10'(k * 200 + r * 13 + 5);
            run_batch(vt[r].mask, vt[r].ord, vt[r].n, $sformatf("rr%0d", r));
        end

        stub_mode = 2;
        ang[0] = 10'd411;
        repeat (3) @(negedge CLK);
        run_batch(4'b0001, 16'h0000, 1, "stale");
        chk("stale_rsp_lat", t_rsp - t_ack, 2);
        stub_mode = 0;
        repeat (2) @(negedge CLK);

        stub_mode = 1;
        ang[2] = 10'd77;
        req = 4'b0100;
        wait_ack("midrst_grant", 4'b0100);
        repeat (4) @(negedge CLK);
        r0 = n_rsp;
        RST = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_start", cordic_start, 0);
        chk("midrst_angle", cordic_angle, 0);
        chk("midrst_id", rsp_id, 0);
        chk("midrst_cos", rsp_cos, 0);
        chk("midrst_valid", rsp_valid, 0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        q.delete();
        stub_mode = 0;
        run_batch(4'b1111, 16'h3210, 4, "postrst");
        chk("midrst_no_rsp", n_rsp - r0, 4);

        stub_mode = 1;
        ang[0] = 10'd300;
        req = 4'b0001;
        wait_ack("to_grant", 4'b0001);
`ifdef CORDIC_ARB_TIMEOUT_EN
        e.id = 0; e.c = '0; e.s = '0; e.err = 1'b1;
        q.push_back(e);
        for (int c = 0; c < 100 && q.size() != 0; c++) @(negedge CLK);
        chk("to_rsp_seen", q.size(), 0);
        chk("to_wait_cycles", t_rsp - t_start, TIMEOUT);
`else
        r0 = n_rsp;
        repeat (60) @(negedge CLK);
        chk("to_busy_held", busy, 1);
        chk("to_no_rsp", n_rsp - r0, 0);
`endif
        stub_mode = 0;
        do_reset();

        a0 = n_ack;
        r0 = n_rsp;
        for (int i = 0; i < 37; i++) begin
            ang[1] = 10'(i * 28);
            run_batch(4'b0010, 16'h0001, 1, "sweep");
        end
        chk("sweep_acks", n_ack - a0, 37);
        chk("sweep_rsps", n_rsp - r0, 37);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
